// File: rtl/game_if.sv
// game_if: board-side inputs and datapath enables around the Starflux sequencer.
interface game_if;
  logic       start_btn;
  logic       ship_hit;
  logic       enemy_hit;
  logic [3:0] ship_health;
  logic       startGameEn;
  logic       shipUpdateEn;
  logic       gridUpdateEn;
  logic       health_update;
  logic       current_score_update;
  logic       gameover_signal;
  logic [2:0] state_out;
  modport master (
    input  start_btn, ship_hit, enemy_hit, ship_health,
    output startGameEn, shipUpdateEn, gridUpdateEn, health_update,
           current_score_update, gameover_signal, state_out
  );
  modport slave (
    output start_btn, ship_hit, enemy_hit, ship_health,
    input  startGameEn, shipUpdateEn, gridUpdateEn, health_update,
           current_score_update, gameover_signal, state_out
  );
endinterface

// File: rtl/game_controller.sv
// game_controller: start/init/frame-loop sequencer for the Starflux datapath.
// Outputs are registered decodes of the next state, so they line up with state_out.
module game_controller #(
  parameter int unsigned FRAME_DIV    = 833333,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned START_CYCLES = 4
) (
  input logic    clk,
  input logic    reset,
  game_if.master ctrl_io
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIP  = 3'd3;
  localparam logic [2:0] S_GRID  = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_OVER  = 3'd6;
  localparam int IW = $clog2(START_CYCLES + 1);
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [IW-1:0]    init_q, init_d;
  logic             start_prev_q;
  logic             start_en_q, ship_q, grid_q, health_q, score_q, over_q;
  logic             start_edge, frame_done, init_done, check_ok;
  assign start_edge = ctrl_io.start_btn & ~start_prev_q;
  assign frame_done = frame_q == CNT_W'(FRAME_DIV - 1);
  assign init_done  = init_q == IW'(START_CYCLES - 1);
  assign check_ok   = (state_q == S_CHECK) && (ctrl_io.ship_health != 4'd0);
  assign frame_d    = (state_q == S_WAIT && !frame_done) ? frame_q + 1'b1 : '0;
  assign init_d     = (state_q == S_INIT && !init_done) ? init_q + 1'b1 : '0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start_edge ? S_INIT : S_IDLE;
      S_INIT:  state_d = init_done ? S_WAIT : S_INIT;
      S_WAIT:  state_d = frame_done ? S_SHIP : S_WAIT;
      S_SHIP:  state_d = S_GRID;
      S_GRID:  state_d = S_CHECK;
      S_CHECK: state_d = (ctrl_io.ship_health == 4'd0) ? S_OVER : S_WAIT;
      S_OVER:  state_d = start_edge ? S_INIT : S_OVER;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      frame_q      <= '0;
      init_q       <= '0;
      start_prev_q <= 1'b0;
      start_en_q   <= 1'b0;
      ship_q       <= 1'b0;
      grid_q       <= 1'b0;
      health_q     <= 1'b0;
      score_q      <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      init_q       <= init_d;
      start_prev_q <= ctrl_io.start_btn;
      start_en_q   <= state_d == S_INIT;
      ship_q       <= state_d == S_SHIP;
      grid_q       <= state_d == S_GRID;
      health_q     <= check_ok & ctrl_io.ship_hit;
      score_q      <= check_ok & ctrl_io.enemy_hit;
      over_q       <= state_d == S_OVER;
    end
  end
  assign ctrl_io.state_out            = state_q;
  assign ctrl_io.startGameEn          = start_en_q;
  assign ctrl_io.shipUpdateEn         = ship_q;
  assign ctrl_io.gridUpdateEn         = grid_q;
  assign ctrl_io.health_update        = health_q;
  assign ctrl_io.current_score_update = score_q;
  assign ctrl_io.gameover_signal      = over_q;
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: scoreboard bench; expected output-vector changes and their
// preceding dwell times are queued by the stimulus and popped by a negedge monitor.
module tb_game_controller;
  typedef struct {
    logic [8:0] v;
    int         d;
  } ev_t;
  logic clk = 1'b0;
  logic reset;
  game_if ifc ();
  game_controller #(.FRAME_DIV(4), .CNT_W(3), .START_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .ctrl_io(ifc)
  );
  always #5 clk = ~clk;
  ev_t        q[$];
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 0;
  bit         armed = 0;
  logic [8:0] prev;
  int         dwell;
  wire [8:0] vec = {ifc.state_out, ifc.startGameEn, ifc.shipUpdateEn, ifc.gridUpdateEn,
                    ifc.health_update, ifc.current_score_update, ifc.gameover_signal};
  function automatic logic [8:0] v(logic [2:0] s, bit sg = 0, bit sh = 0, bit gr = 0,
                                   bit hu = 0, bit sc = 0, bit go = 0);
    return {s, sg, sh, gr, hu, sc, go};
  endfunction
  task automatic push(logic [8:0] val, int d);
    ev_t e;
    e.v = val;
    e.d = d;
    q.push_back(e);
  endtask
  task automatic push_frame(int wait_dwell);
    push(v(3, 0, 1), wait_dwell);
    push(v(4, 0, 0, 1), 1);
    push(v(5), 1);
    push(v(2), 1);
  endtask
  task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic drain(string name, int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      step(1);
      n++;
    end
    chk(name, 9'(q.size()), 9'd0);
    q.delete();
  endtask
  always @(negedge clk) begin
    if (!mon_en) armed = 0;
    else if (!armed) begin
      prev  = vec;
      dwell = 1;
      armed = 1;
    end else if (vec == prev) dwell++;
    else begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change: got %b after %0d cycles, expected no change", vec, dwell);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (vec !== e.v || (e.d != 0 && dwell != e.d)) begin
          miscompares++;
          $display("FAIL event: got %b after dwell %0d, expected %b after dwell %0d",
                   vec, dwell, e.v, e.d);
        end
      end
      prev  = vec;
      dwell = 1;
    end
  end
  initial begin
    reset = 1'b0;
    ifc.start_btn = 0;
    ifc.ship_hit = 0;
    ifc.enemy_hit = 0;
    ifc.ship_health = 4'd5;
    step(2);
    chk("reset_state", vec, 9'd0);
    reset = 1'b1;
    step(1);
    mon_en = 1;
    step(2);
    push(v(1, 1), 0);
    push(v(2), 2);
    push_frame(4);
    push_frame(4);
    ifc.start_btn = 1;
    step(3);
    ifc.start_btn = 0;
    drain("play_no_hits", 40);
    push(v(3, 0, 1), 4);
    push(v(4, 0, 0, 1), 1);
    push(v(5), 1);
    push(v(2, 0, 0, 0, 1, 1), 1);
    push(v(2), 1);
    push_frame(3);
    ifc.ship_hit = 1;
    ifc.enemy_hit = 1;
    ifc.start_btn = 1;
    step(1);
    ifc.start_btn = 0;
    step(6);
    ifc.ship_hit = 0;
    ifc.enemy_hit = 0;
    drain("hits_and_wait_start", 40);
    push(v(3, 0, 1), 4);
    push(v(4, 0, 0, 1), 1);
    push(v(5), 1);
    push(v(6, 0, 0, 0, 0, 0, 1), 1);
    ifc.ship_health = 4'd0;
    ifc.ship_hit = 1;
    ifc.start_btn = 1;
    drain("enter_over", 40);
    ifc.ship_hit = 0;
    step(5);
    chk("over_hold_start_high", vec, v(6, 0, 0, 0, 0, 0, 1));
    ifc.start_btn = 0;
    step(2);
    push(v(1, 1), 0);
    push(v(2), 2);
    ifc.ship_health = 4'd5;
    ifc.start_btn = 1;
    step(1);
    chk("restart_from_over", vec, v(1, 1));
    ifc.start_btn = 0;
    drain("restart_init", 20);
    mon_en = 0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_mid_wait", vec, 9'd0);
    step(1);
    reset = 1'b1;
    step(3);
    chk("idle_after_reset", vec, 9'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
